vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 35 +++
 rtl/sync2ff.sv | 28 ++
 rtl/vga_timing_gen.sv | 200 ++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing generator.
//   - Default 640x480@60 timing constants (pixel clock ~25.175 MHz).
//   - Pixel/line counter width.
//   - FSM state encoding.
//   - Helper to total the four segments of a line or frame.
package vga_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;

    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    // Sync pulses are active-low in the 640x480 mode.
    localparam logic SYNC_POL_DEF = 1'b0;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } vga_state_e;

    function automatic int unsigned vga_total(input int unsigned active,
                                              input int unsigned fp,
                                              input int unsigned sync,
                                              input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/sync2ff.sv
// Two-flop synchroniser for a single asynchronous level.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, clears both stages
//   d_i    : asynchronous input level
//   q_o    : synchronised level, two clk_i edges after d_i settles
module sync2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
//
// Scans an HT x VT raster while running; all outputs are registered one cycle
// after the h/v counters, so hsync, vsync, de and the pixel coordinates line up.
//
// Ports:
//   vgaClk      : pixel clock, sole clock of the block
//   reset_n     : asynchronous active-low reset
//   pllLocked   : raw PLL lock, asynchronous; only used through sync2ff
//   enable      : request to scan; dropping it finishes the current frame
//   hsync/vsync : sync outputs, active level SYNC_POL
//   de          : display enable (visible pixel)
//   pixelX/Y    : visible pixel coordinates, 0 outside the visible area
//   lineStart   : one-cycle pulse at h=0
//   frameStart  : one-cycle pulse at h=0, v=0
//   frameCount  : frame counter, increments with frameStart, wraps
//   running     : 1 while outputs reflect an active scan
//   irq/irqAck  : frame interrupt and its acknowledge, present only when
//                 VGA_TIMING_FRAME_IRQ_EN is defined
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter logic        SYNC_POL = SYNC_POL_DEF
) (
    input  logic             vgaClk,
    input  logic             reset_n,
    input  logic             pllLocked,
    input  logic             enable,
`ifdef VGA_TIMING_FRAME_IRQ_EN
    input  logic             irqAck,
    output logic             irq,
`endif
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] pixelX,
    output logic [CNT_W-1:0] pixelY,
    output logic             lineStart,
    output logic             frameStart,
    output logic [15:0]      frameCount,
    output logic             running
);

    localparam int unsigned HT = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned VT = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(HT - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(VT - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic lock_s;

    sync2ff u_lock_sync (
        .clk_i  (vgaClk),
        .rst_ni (reset_n),
        .d_i    (pllLocked),
        .q_o    (lock_s)
    );

    vga_state_e       state_q, state_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             de_q, de_d;
    logic [CNT_W-1:0] pix_x_q, pix_x_d;
    logic [CNT_W-1:0] pix_y_q, pix_y_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic [15:0]      frame_count_q, frame_count_d;
    logic             running_q, running_d;

    logic run_active;
    logic h_last;
    logic v_last;

    always_comb begin
        // Lock loss gates the current cycle directly so the outputs drop on
        // the very next edge instead of emitting one more stale pixel.
        run_active = (state_q == StRun) && lock_s;
        h_last     = (h_q == H_LAST);
        v_last     = (v_q == V_LAST);

        state_d = state_q;
        unique case (state_q)
            StIdle: if (lock_s && enable) state_d = StRun;
            StRun: begin
                if (!lock_s) begin
                    state_d = StIdle;
                end else if (h_last && v_last && !enable) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Counters return to 0 whenever the scan stops so re-entry starts at
        // the top-left pixel.
        h_d = '0;
        v_d = '0;
        if (run_active && (state_d == StRun)) begin
            h_d = h_last ? '0 : h_q + 1'b1;
            if (h_last) begin
                v_d = v_last ? '0 : v_q + 1'b1;
            end else begin
                v_d = v_q;
            end
        end

        de_d    = run_active && (h_q < H_VIS) && (v_q < V_VIS);
        hsync_d = (run_active && (h_q >= HS_START) && (h_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vsync_d = (run_active && (v_q >= VS_START) && (v_q < VS_END)) ? SYNC_POL : ~SYNC_POL;
        pix_x_d = de_d ? h_q : '0;
        pix_y_d = de_d ? v_q : '0;

        line_start_d  = run_active && (h_q == '0);
        frame_start_d = line_start_d && (v_q == '0);
        frame_count_d = frame_start_d ? frame_count_q + 16'd1 : frame_count_q;
        running_d     = run_active;
    end

    always_ff @(posedge vgaClk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            h_q           <= '0;
            v_q           <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            de_q          <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
            running_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
            running_q     <= running_d;
        end
    end

    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign de         = de_q;
    assign pixelX     = pix_x_q;
    assign pixelY     = pix_y_q;
    assign lineStart  = line_start_q;
    assign frameStart = frame_start_q;
    assign frameCount = frame_count_q;
    assign running    = running_q;

`ifdef VGA_TIMING_FRAME_IRQ_EN
    logic irq_q, irq_d;

    // Set follows the registered frameStart, so an ack presented during the
    // frameStart cycle loses to the set.
    always_comb begin
        irq_d = irq_q;
        if (frame_start_q) begin
            irq_d = 1'b1;
        end else if (irqAck) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge vgaClk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using a reduced raster:
//   H: 8 visible, 2 FP, 3 sync, 3 BP -> HT=16, hsync low at h=10..12
//   V: 6 visible, 1 FP, 2 sync, 2 BP -> VT=11, vsync low at v=7..8
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_vga_timing_gen;

    localparam int HT    = 16;
    localparam int VT    = 11;
    localparam int FRAME = HT * VT;

    logic        vgaClk = 1'b0;
    logic        reset_n;
    logic        pllLocked;
    logic        enable;
    logic        hsync, vsync, de, lineStart, frameStart, running;
    logic [9:0]  pixelX, pixelY;
    logic [15:0] frameCount;
`ifdef VGA_TIMING_FRAME_IRQ_EN
    logic        irqAck;
    logic        irq;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 vgaClk = ~vgaClk;

    vga_timing_gen #(
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (3),
        .V_ACTIVE (6),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (2),
        .SYNC_POL (1'b0)
    ) dut (
        .vgaClk     (vgaClk),
        .reset_n    (reset_n),
        .pllLocked  (pllLocked),
        .enable     (enable),
`ifdef VGA_TIMING_FRAME_IRQ_EN
        .irqAck     (irqAck),
        .irq        (irq),
`endif
        .hsync      (hsync),
        .vsync      (vsync),
        .de         (de),
        .pixelX     (pixelX),
        .pixelY     (pixelY),
        .lineStart  (lineStart),
        .frameStart (frameStart),
        .frameCount (frameCount),
        .running    (running)
    );

    task automatic step(input int n);
        for (int k = 0; k < n; k++) @(negedge vgaClk);
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        pllLocked = 1'b0;
        enable    = 1'b0;
`ifdef VGA_TIMING_FRAME_IRQ_EN
        irqAck    = 1'b0;
`endif
        step(3);
        n_cmp++;
        if ({hsync, vsync, de, lineStart, frameStart, running} !== 6'b110000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b expected 110000",
                     {hsync, vsync, de, lineStart, frameStart, running});
        end
        n_cmp++;
        if ({pixelX, pixelY, frameCount} !== 36'd0) begin
            n_bad++;
            $display("FAIL reset_data: got x=%0d y=%0d fc=%0d expected 0 0 0",
                     pixelX, pixelY, frameCount);
        end
`ifdef VGA_TIMING_FRAME_IRQ_EN
        n_cmp++;
        if (irq !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_irq: got %b expected 0", irq);
        end
`endif
    endtask

    // Reset release with lock and enable already up: 2 sync edges, 1 FSM
    // edge, 1 output edge.
    task automatic test_startup();
        int cyc;
        reset_n   = 1'b1;
        pllLocked = 1'b1;
        enable    = 1'b1;
        cyc = 0;
        while (running !== 1'b1 && cyc < 10) begin
            step(1);
            cyc++;
        end
        n_cmp++;
        if (cyc != 4) begin
            n_bad++;
            $display("FAIL startup_latency: got %0d cycles expected 4", cyc);
        end
        n_cmp++;
        if ({de, frameStart, lineStart, pixelX, pixelY} !== {3'b111, 20'd0}) begin
            n_bad++;
            $display("FAIL startup_first_pixel: got de=%b fs=%b ls=%b x=%0d y=%0d expected 1 1 1 0 0",
                     de, frameStart, lineStart, pixelX, pixelY);
        end
    endtask

    // Walk one full frame starting on the frameStart cycle.
    task automatic test_frame();
        int de_cnt, hs_low, vs_low, ls_cnt, fs_cnt, pos_err, run_err, first_bad;
        de_cnt = 0; hs_low = 0; vs_low = 0; ls_cnt = 0; fs_cnt = 0;
        pos_err = 0; run_err = 0; first_bad = -1;
        for (int i = 0; i < FRAME; i++) begin
            int x;
            int y;
            logic e_de, e_hs, e_vs, e_ls, e_fs;
            logic [9:0] e_px, e_py;
            x = i % HT;
            y = i / HT;
            e_de = (x < 8) && (y < 6);
            e_hs = !((x >= 10) && (x < 13));
            e_vs = !((y >= 7) && (y < 9));
            e_ls = (x == 0);
            e_fs = (x == 0) && (y == 0);
            e_px = e_de ? 10'(x) : 10'd0;
            e_py = e_de ? 10'(y) : 10'd0;
            if ({de, hsync, vsync, lineStart, frameStart, pixelX, pixelY} !==
                {e_de, e_hs, e_vs, e_ls, e_fs, e_px, e_py}) begin
                pos_err++;
                if (first_bad < 0) first_bad = i;
            end
            if (running !== 1'b1) run_err++;
            if (de === 1'b1) de_cnt++;
            if (hsync === 1'b0) hs_low++;
            if (vsync === 1'b0) vs_low++;
            if (lineStart === 1'b1) ls_cnt++;
            if (frameStart === 1'b1) fs_cnt++;
            step(1);
        end
        n_cmp++;
        if (pos_err != 0) begin
            n_bad++;
            $display("FAIL frame_pixels: got %0d bad cycles (first at %0d) expected 0",
                     pos_err, first_bad);
        end
        n_cmp++;
        if (de_cnt != 48) begin
            n_bad++;
            $display("FAIL frame_de_count: got %0d expected 48", de_cnt);
        end
        n_cmp++;
        if (hs_low != 33) begin
            n_bad++;
            $display("FAIL frame_hsync_low: got %0d expected 33", hs_low);
        end
        n_cmp++;
        if (vs_low != 32) begin
            n_bad++;
            $display("FAIL frame_vsync_low: got %0d expected 32", vs_low);
        end
        n_cmp++;
        if (ls_cnt != 11 || fs_cnt != 1 || run_err != 0) begin
            n_bad++;
            $display("FAIL frame_pulses: got ls=%0d fs=%0d run_err=%0d expected 11 1 0",
                     ls_cnt, fs_cnt, run_err);
        end
        // Next frame begins exactly FRAME cycles later.
        n_cmp++;
        if (frameStart !== 1'b1) begin
            n_bad++;
            $display("FAIL frame_period: got frameStart=%b expected 1", frameStart);
        end
        step(1);
        n_cmp++;
        if (frameCount !== 16'd2) begin
            n_bad++;
            $display("FAIL frame_count: got %0d expected 2", frameCount);
        end
    endtask

    // Entered at output position x=1,y=0.
    task automatic test_lock_loss();
        int cyc;
        logic [15:0] fc;
        step(58);  // now at x=11,y=3, inside the hsync pulse
        n_cmp++;
        if ({hsync, running} !== 2'b01) begin
            n_bad++;
            $display("FAIL lock_pre: got hsync=%b running=%b expected 0 1", hsync, running);
        end
        fc = frameCount;
        pllLocked = 1'b0;
        cyc = 0;
        while (running !== 1'b0 && cyc < 10) begin
            step(1);
            cyc++;
        end
        n_cmp++;
        if (cyc != 3) begin
            n_bad++;
            $display("FAIL lock_drop_latency: got %0d cycles expected 3", cyc);
        end
        n_cmp++;
        if ({de, hsync, vsync} !== 3'b011) begin
            n_bad++;
            $display("FAIL lock_drop_outputs: got de=%b hs=%b vs=%b expected 0 1 1",
                     de, hsync, vsync);
        end
        step(20);
        n_cmp++;
        if (frameCount !== fc || running !== 1'b0) begin
            n_bad++;
            $display("FAIL lock_idle_hold: got fc=%0d running=%b expected %0d 0",
                     frameCount, running, fc);
        end
        pllLocked = 1'b1;
        cyc = 0;
        while (frameStart !== 1'b1 && cyc < 10) begin
            step(1);
            cyc++;
        end
        n_cmp++;
        if (cyc != 4) begin
            n_bad++;
            $display("FAIL lock_restart_latency: got %0d cycles expected 4", cyc);
        end
        n_cmp++;
        if ({de, running, pixelX, pixelY} !== {2'b11, 20'd0}) begin
            n_bad++;
            $display("FAIL lock_restart_pos: got de=%b run=%b x=%0d y=%0d expected 1 1 0 0",
                     de, running, pixelX, pixelY);
        end
        step(1);
        n_cmp++;
        if (frameCount !== fc + 16'd1) begin
            n_bad++;
            $display("FAIL lock_restart_count: got %0d expected %0d", frameCount, fc + 16'd1);
        end
    endtask

    // Entered at output position x=1,y=0 with frameCount=3.
    task automatic test_enable_stop();
        int cyc, fs_seen;
        logic last_hs, last_vs;
        step(31);  // x=0,y=2
        enable  = 1'b0;
        cyc     = 0;
        fs_seen = 0;
        last_hs = 1'b0;
        last_vs = 1'b0;
        while (running === 1'b1 && cyc < 400) begin
            last_hs = hsync;
            last_vs = vsync;
            step(1);
            cyc++;
            if (frameStart === 1'b1) fs_seen++;
        end
        n_cmp++;
        if (cyc != FRAME - 32) begin
            n_bad++;
            $display("FAIL stop_drain: got %0d cycles expected %0d", cyc, FRAME - 32);
        end
        n_cmp++;
        if ({fs_seen != 0, last_hs, last_vs} !== 3'b011) begin
            n_bad++;
            $display("FAIL stop_last_pixel: got fs=%0d hs=%b vs=%b expected 0 1 1",
                     fs_seen, last_hs, last_vs);
        end
        step(20);
        n_cmp++;
        if (frameCount !== 16'd3 || running !== 1'b0) begin
            n_bad++;
            $display("FAIL stop_count: got fc=%0d running=%b expected 3 0", frameCount, running);
        end
    endtask

    task automatic test_wrap();
        int cyc;
        force dut.frame_count_q = 16'hFFFF;
        step(2);
        release dut.frame_count_q;
        step(1);
        n_cmp++;
        if (frameCount !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL wrap_preload: got %0d expected 65535", frameCount);
        end
        enable = 1'b1;
        cyc = 0;
        while (frameStart !== 1'b1 && cyc < 10) begin
            step(1);
            cyc++;
        end
        n_cmp++;
        if (cyc != 2) begin
            n_bad++;
            $display("FAIL wrap_start_latency: got %0d cycles expected 2", cyc);
        end
        step(1);
        n_cmp++;
        if (frameCount !== 16'd0) begin
            n_bad++;
            $display("FAIL wrap_value: got %0d expected 0", frameCount);
        end
    endtask

`ifdef VGA_TIMING_FRAME_IRQ_EN
    task automatic test_irq();
        int cyc;
        cyc = 0;
        while (frameStart !== 1'b1 && cyc < 400) begin
            step(1);
            cyc++;
        end
        irqAck = 1'b1;
        step(1);
        n_cmp++;
        if (irq !== 1'b1) begin
            n_bad++;
            $display("FAIL irq_set_wins: got %b expected 1", irq);
        end
        step(1);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_bad++;
            $display("FAIL irq_ack: got %b expected 0", irq);
        end
        irqAck = 1'b0;
    endtask
`endif

    // Asynchronous reset during a scan clears outputs without a clock edge.
    task automatic test_async_reset();
        step(5);
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({running, de, hsync, vsync, frameCount} !== {4'b0011, 16'd0}) begin
            n_bad++;
            $display("FAIL async_reset: got run=%b de=%b hs=%b vs=%b fc=%0d expected 0 0 1 1 0",
                     running, de, hsync, vsync, frameCount);
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_frame();
        test_lock_loss();
        test_enable_stop();
        test_wrap();
`ifdef VGA_TIMING_FRAME_IRQ_EN
        test_irq();
`endif
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
